mux_skid_reg: RTL and testbench

Parametrised N-input, W-bit select stage with a registered, back-pressured output: the successor to the fixed 3-input 32-bit operand/forwarding mux. It sits between the hazard/forwarding select logic and the next pipeline stage (e.g. ID/EX operand capture). It registers the selected word behind a valid/ready handshake with a one-entry skid buffer, so upstream `ready_o` is a pure register output and full throughput is kept under stall.

---
 rtl/mux_skid_reg.sv | 140 ++++++++++++++
 tb/tb_mux_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_skid_reg.sv
// mux_skid_reg: N-input, WIDTH-bit select stage with a registered output and
// a one-entry skid buffer behind a valid/ready handshake.
//
// Optional feature: define MUX_SKID_SELCHK_EN to build the sticky
// out-of-range select checker driving sel_err_o; otherwise sel_err_o is 0.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   data_i     NUM_IN flattened words, input k at [k*WIDTH +: WIDTH]
//   select_i   input index; out-of-range selects yield an all-zero word
//   valid_i    upstream word valid
//   ready_o    stage can accept a word (registered)
//   flush_i    synchronous discard of all held words
//   data_o     registered selected word
//   valid_o    data_o valid
//   ready_i    downstream accepts
//   sel_err_o  sticky out-of-range select flag
module mux_skid_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    sel_err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic [WIDTH-1:0] sel_w;
  logic             valid_q, ready_q;
  logic             accept, pop;

  // Input select; indices at or above NUM_IN match no lane and give zero.
  always_comb begin
    sel_w = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) sel_w = data_i[k*WIDTH +: WIDTH];
    end
  end

  assign accept = valid_i & ready_q;
  assign pop    = valid_q & ready_i;

  // Next state and datapath; flush overrides accept and pop.
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush_i) begin
      state_n = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_n = ST_ONE;
            main_n  = sel_w;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_n = sel_w;
          end else if (accept) begin
            state_n = ST_TWO;
            skid_n  = sel_w;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_n = ST_ONE;
            main_n  = skid_q;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // State and storage registers; valid/ready flops decode next state so the
  // outputs never see a combinational path from ready_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      valid_q <= (state_n != ST_EMPTY);
      ready_q <= (state_n != ST_TWO);
    end
  end

  assign data_o  = main_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;

`ifdef MUX_SKID_SELCHK_EN
  logic sel_oor;
  logic sel_err_q;

  // Zero-extend by one bit so NUM_IN itself is representable.
  assign sel_oor = ({1'b0, select_i} >= (SEL_W + 1)'(NUM_IN));

  // Sticky until reset; flush intentionally leaves it alone.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err_o = sel_err_q;
`else
  assign sel_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_skid_reg.sv
// Self-checking bench for mux_skid_reg: table-driven vectors on a 3x32
// instance, hand sequences for async reset and the select checker on a 5x32
// instance, and a randomized queue-model run on a 16x8 instance.
module tb_mux_skid_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: 3 inputs, 32 bits
  logic [95:0]  d3;
  logic [1:0]   s3;
  logic         v3, rdy3, fl3;
  logic [31:0]  q3;
  logic         vo3, ro3, se3;

  // Instance B: 5 inputs, 32 bits (select checker)
  logic [159:0] d5;
  logic [2:0]   s5;
  logic         v5, rdy5, fl5;
  logic [31:0]  q5;
  logic         vo5, ro5, se5;

  // Instance C: 16 inputs, 8 bits (random run)
  logic [127:0] d16;
  logic [3:0]   s16;
  logic         v16, rdy16, fl16;
  logic [7:0]   q16;
  logic         vo16, ro16, se16;

  mux_skid_reg #(.WIDTH(32), .NUM_IN(3)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d3), .select_i(s3), .valid_i(v3),
    .ready_o(ro3), .flush_i(fl3), .data_o(q3), .valid_o(vo3), .ready_i(rdy3),
    .sel_err_o(se3));

  mux_skid_reg #(.WIDTH(32), .NUM_IN(5)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d5), .select_i(s5), .valid_i(v5),
    .ready_o(ro5), .flush_i(fl5), .data_o(q5), .valid_o(vo5), .ready_i(rdy5),
    .sel_err_o(se5));

  mux_skid_reg #(.WIDTH(8), .NUM_IN(16)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d16), .select_i(s16), .valid_i(v16),
    .ready_o(ro16), .flush_i(fl16), .data_o(q16), .valid_o(vo16), .ready_i(rdy16),
    .sel_err_o(se16));

`ifdef MUX_SKID_SELCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        rdy;
    logic        fl;
    logic [31:0] d0;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mq[$];
  logic [7:0] w;
  logic       acc, pop;

  initial begin
    rst_n = 1'b0;
    d3 = '0; s3 = '0; v3 = 1'b0; rdy3 = 1'b0; fl3 = 1'b0;
    d5 = '0; s5 = '0; v5 = 1'b0; rdy5 = 1'b0; fl5 = 1'b0;
    d16 = '0; s16 = '0; v16 = 1'b0; rdy16 = 1'b0; fl16 = 1'b0;

    // Stream table: legacy select mapping, back-pressure, flush in TWO and ONE
    //               v     sel   rdy   fl    d0             ev    ed             er
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h11111111, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h22222222, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h33333333, 1'b1});
    vecs.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 32'h11111111, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h00000001, 1'b1, 32'h00000001, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 32'h00000002, 1'b1, 32'h00000001, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 32'h00000003, 1'b1, 32'h00000001, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h00000003, 1'b1, 32'h00000002, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h00000003, 1'b1, 32'h00000003, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h00000004, 1'b1, 32'h00000004, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000004, 1'b0, 32'h00000004, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 32'h00000005, 1'b1, 32'h00000005, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 32'h00000006, 1'b1, 32'h00000005, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 32'h00000007, 1'b0, 32'h00000005, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000007, 1'b0, 32'h00000005, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h00000008, 1'b1, 32'h00000008, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000008, 1'b0, 32'h00000008, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 32'h00000009, 1'b1, 32'h00000009, 1'b1});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 32'h0000000A, 1'b0, 32'h00000009, 1'b1});

    // Reset values
    tick(); tick();
    check("rst_valid", 32'(vo3), 32'd0);
    check("rst_data", q3, 32'd0);
    check("rst_ready", 32'(ro3), 32'd1);
    check("rst_sel_err", 32'(se5), 32'd0);
    rst_n = 1'b1;

    // Table-driven stream on instance A
    d3 = {32'h33333333, 32'h22222222, 32'h11111111};
    foreach (vecs[i]) begin
      d3[31:0] = vecs[i].d0;
      s3   = vecs[i].sel;
      v3   = vecs[i].v;
      rdy3 = vecs[i].rdy;
      fl3  = vecs[i].fl;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(vo3), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i), q3, vecs[i].ed);
      check($sformatf("vec%0d_ready", i), 32'(ro3), 32'(vecs[i].er));
    end
    v3 = 1'b0; fl3 = 1'b0;

    // Asynchronous reset while two words are held
    d3[31:0] = 32'hAAAA5555; s3 = 2'd0; v3 = 1'b1; rdy3 = 1'b0;
    tick(); tick();
    check("pre_arst_valid", 32'(vo3), 32'd1);
    check("pre_arst_ready", 32'(ro3), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(vo3), 32'd0);
    check("arst_data", q3, 32'd0);
    check("arst_ready", 32'(ro3), 32'd1);
    v3 = 1'b0;
    tick();
    rst_n = 1'b1;

    // Select checker on instance B (NUM_IN=5)
    d5 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h10101010};
    rdy5 = 1'b1; v5 = 1'b1; s5 = 3'd4;
    tick();
    check("sel4_data", q5, 32'h44444444);
    check("sel4_err", 32'(se5), 32'd0);
    s5 = 3'd7;
    tick();
    check("sel7_valid", 32'(vo5), 32'd1);
    check("sel7_data", q5, 32'd0);
    check("sel7_err", 32'(se5), 32'(EXP_ERR));
    s5 = 3'd1; fl5 = 1'b1;
    tick();
    check("flush_valid", 32'(vo5), 32'd0);
    check("flush_ready", 32'(ro5), 32'd1);
    check("flush_err", 32'(se5), 32'(EXP_ERR));
    fl5 = 1'b0; v5 = 1'b0;
    tick();
    check("post_flush_err", 32'(se5), 32'(EXP_ERR));

    // Randomized run on instance C against a queue model
    for (int c = 0; c < 10000; c++) begin
      d16   = {$urandom, $urandom, $urandom, $urandom};
      s16   = 4'($urandom_range(0, 15));
      v16   = ($urandom_range(0, 3) != 0);
      rdy16 = ($urandom_range(0, 2) != 0);
      fl16  = ($urandom_range(0, 63) == 0);
      w     = d16[s16*8 +: 8];
      acc   = v16 && (mq.size() < 2);
      pop   = (mq.size() > 0) && rdy16;
      @(posedge clk);
      if (fl16) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(w);
      end
      #1;
      check($sformatf("rnd%0d_valid", c), 32'(vo16), 32'(mq.size() > 0));
      check($sformatf("rnd%0d_ready", c), 32'(ro16), 32'(mq.size() < 2));
      if (mq.size() > 0) check($sformatf("rnd%0d_data", c), 32'(q16), 32'(mq[0]));
      // ready_o must not follow ready_i between edges
      rdy16 = ~rdy16;
      #1;
      check($sformatf("rnd%0d_ready_iso", c), 32'(ro16), 32'(mq.size() < 2));
    end
    check("pow2_sel_err", 32'(se16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
